// File: rtl/css_mcu0_el2_pkg.sv
// rtl/css_mcu0_el2_pkg.sv - PMP CSR addresses, cfg/mseccfg packet types and mask helper
package css_mcu0_el2_pkg;

  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
  localparam logic [11:0] MSECCFG      = 12'h747;
  localparam logic [11:0] MSECCFGH     = 12'h757;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } el2_pmp_mode_t;

  typedef struct packed {
    logic          lock;
    logic [1:0]    reserved;
    el2_pmp_mode_t mode;
    logic          execute;
    logic          write;
    logic          read;
  } el2_pmp_cfg_pkt_t;

  typedef struct packed {
    logic RLB;
    logic MMWP;
    logic MML;
  } el2_mseccfg_pkt_t;

  // n low bits set; n <= 0 gives zero, so callers may pass G-1 without guarding
  function automatic logic [31:0] low_ones(input int n);
    logic [31:0] m;
    for (int b = 0; b < 32; b++) m[b] = (b < n);
    return m;
  endfunction

endpackage

// File: rtl/css_mcu0_el2_pmp_cfg_legalize.sv
// rtl/css_mcu0_el2_pmp_cfg_legalize.sv - WARL/lock legalization of one pmpcfg byte
module css_mcu0_el2_pmp_cfg_legalize
  import css_mcu0_el2_pkg::*;
#(
  parameter int PMP_GRANULARITY = 0
) (
  input  el2_pmp_cfg_pkt_t i_old_cfg,
  input  logic [7:0]       i_new_byte,
  input  logic             i_locked,
  input  logic             i_mml,
  input  logic             i_rlb,
  output el2_pmp_cfg_pkt_t o_next_cfg
);

  el2_pmp_cfg_pkt_t w_new;
  logic             w_rw_reserved;
  logic             w_mml_block;

  always_comb begin
    w_new          = el2_pmp_cfg_pkt_t'(i_new_byte);
    w_new.reserved = 2'b00;
    w_rw_reserved  = ~i_mml & ~w_new.read & w_new.write;
    // locked executable / W-only rules are blocked under MML, except the shared RWX encoding
    w_mml_block    = i_mml & ~i_rlb & w_new.lock
                   & (w_new.execute | (~w_new.read & w_new.write))
                   & ~(w_new.read & w_new.write & w_new.execute);
    o_next_cfg = w_new;
    if (PMP_GRANULARITY >= 1 && w_new.mode == NA4) o_next_cfg.mode = i_old_cfg.mode;
    if (i_locked || w_rw_reserved || w_mml_block) o_next_cfg = i_old_cfg;
  end

endmodule

// File: rtl/css_mcu0_el2_pmp_csr.sv
// rtl/css_mcu0_el2_pmp_csr.sv - PMP/Smepmp CSR state with lock rules, WARL writes and read mux
module css_mcu0_el2_pmp_csr
  import css_mcu0_el2_pkg::*;
#(
  parameter int PMP_GRANULARITY = 0,
  parameter int PMP_ENTRIES     = 16
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             csr_wr_en,
  input  logic             csr_rd_en,
  input  logic [11:0]      csr_addr,
  input  logic [31:0]      csr_wdata,
  output logic [31:0]      csr_rdata,
  output logic             csr_hit,
  output el2_pmp_cfg_pkt_t pmp_pmpcfg  [PMP_ENTRIES],
  output logic [31:0]      pmp_pmpaddr [PMP_ENTRIES],
  output el2_mseccfg_pkt_t mseccfg,
  output logic             pmp_update
);

  localparam logic [31:0] NAPOT_SET = low_ones(PMP_GRANULARITY - 1);
  localparam logic [31:0] OFF_CLR   = low_ones(PMP_GRANULARITY);

  el2_pmp_cfg_pkt_t        r_cfg [PMP_ENTRIES];
  logic [31:0]             r_addr [PMP_ENTRIES];
  el2_mseccfg_pkt_t        r_msec;
  logic                    r_update;

  el2_pmp_cfg_pkt_t        w_legal    [PMP_ENTRIES];
  el2_pmp_cfg_pkt_t        w_cfg_next [PMP_ENTRIES];
  logic [31:0]             w_addr_next [PMP_ENTRIES];
  el2_mseccfg_pkt_t        w_msec_next;
  logic [PMP_ENTRIES-1:0]  w_locked;
  logic [PMP_ENTRIES-1:0]  w_addr_lock;
  logic [11:0]             w_addr_off;
  logic                    w_is_cfg, w_is_addr, w_is_msec, w_any_lock, w_changed;

  assign w_addr_off = csr_addr - PMPADDR_BASE;
  assign w_is_cfg   = (csr_addr[11:4] == PMPCFG_BASE[11:4]);
  assign w_is_addr  = (w_addr_off < 12'd64);
  assign w_is_msec  = (csr_addr == MSECCFG);
  assign csr_hit    = w_is_cfg | w_is_addr | w_is_msec | (csr_addr == MSECCFGH);

  for (genvar g = 0; g < PMP_ENTRIES; g++) begin : g_ent
    css_mcu0_el2_pmp_cfg_legalize #(.PMP_GRANULARITY(PMP_GRANULARITY)) u_legalize (
      .i_old_cfg  (r_cfg[g]),
      .i_new_byte (csr_wdata[8*(g%4) +: 8]),
      .i_locked   (w_locked[g]),
      .i_mml      (r_msec.MML),
      .i_rlb      (r_msec.RLB),
      .o_next_cfg (w_legal[g])
    );
  end

  always_comb begin
    w_any_lock = 1'b0;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      w_locked[i] = r_cfg[i].lock & ~r_msec.RLB;
      w_any_lock  = w_any_lock | r_cfg[i].lock;
    end
    w_addr_lock = w_locked;
    // a locked TOR entry also freezes the address below it (its lower bound)
    for (int i = 0; i < PMP_ENTRIES - 1; i++)
      if (w_locked[i+1] && r_cfg[i+1].mode == TOR) w_addr_lock[i] = 1'b1;

    w_changed = 1'b0;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      w_cfg_next[i]  = r_cfg[i];
      w_addr_next[i] = r_addr[i];
      if (csr_wr_en && w_is_cfg && csr_addr[3:0] == 4'(i / 4)) w_cfg_next[i] = w_legal[i];
      if (csr_wr_en && w_is_addr && w_addr_off[5:0] == 6'(i) && !w_addr_lock[i])
        w_addr_next[i] = csr_wdata;
      w_changed = w_changed | (w_cfg_next[i] != r_cfg[i]) | (w_addr_next[i] != r_addr[i]);
    end

    w_msec_next = r_msec;
    if (csr_wr_en && w_is_msec) begin
      w_msec_next.MML  = r_msec.MML  | csr_wdata[0];
      w_msec_next.MMWP = r_msec.MMWP | csr_wdata[1];
      if (!csr_wdata[2])                  w_msec_next.RLB = 1'b0;
      else if (r_msec.RLB || !w_any_lock) w_msec_next.RLB = 1'b1;
    end
    w_changed = w_changed | (w_msec_next != r_msec);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        r_cfg[i]  <= '0;
        r_addr[i] <= '0;
      end
      r_msec   <= '0;
      r_update <= 1'b0;
    end else begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        r_cfg[i]  <= w_cfg_next[i];
        r_addr[i] <= w_addr_next[i];
      end
      r_msec   <= w_msec_next;
      r_update <= w_changed;
    end
  end

  // pmpaddr reads reflect the grain; the stored value itself is never masked
  always_comb begin
    csr_rdata = '0;
    if (csr_rd_en) begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        if (w_is_cfg && csr_addr[3:0] == 4'(i / 4)) csr_rdata[8*(i%4) +: 8] = r_cfg[i];
        if (w_is_addr && w_addr_off[5:0] == 6'(i)) begin
          csr_rdata = r_addr[i];
          if (r_cfg[i].mode == NAPOT)
            csr_rdata = r_addr[i] | NAPOT_SET;
          else if (r_cfg[i].mode == OFF || r_cfg[i].mode == TOR)
            csr_rdata = r_addr[i] & ~OFF_CLR;
        end
      end
      if (w_is_msec) csr_rdata = {29'b0, r_msec};
    end
  end

  always_comb begin
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      pmp_pmpcfg[i]  = r_cfg[i];
      pmp_pmpaddr[i] = r_addr[i];
    end
  end

  assign mseccfg    = r_msec;
  assign pmp_update = r_update;

endmodule

// File: tb/tb_css_mcu0_el2_pmp_csr.sv
// tb/tb_css_mcu0_el2_pmp_csr.sv - directed bench; G=0 and G=2 instances share one CSR port
module tb_css_mcu0_el2_pmp_csr;
  import css_mcu0_el2_pkg::*;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata0, rdata2;
  logic hit0, hit2, upd0, upd2;
  el2_pmp_cfg_pkt_t cfgo0 [16];
  el2_pmp_cfg_pkt_t cfgo2 [16];
  logic [31:0] addro0 [16];
  logic [31:0] addro2 [16];
  el2_mseccfg_pkt_t msec0, msec2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  css_mcu0_el2_pmp_csr #(.PMP_GRANULARITY(0), .PMP_ENTRIES(16)) dut0 (
    .clk(clk), .rst_l(rst_l), .csr_wr_en(wr_en), .csr_rd_en(rd_en), .csr_addr(addr),
    .csr_wdata(wdata), .csr_rdata(rdata0), .csr_hit(hit0), .pmp_pmpcfg(cfgo0),
    .pmp_pmpaddr(addro0), .mseccfg(msec0), .pmp_update(upd0));

  css_mcu0_el2_pmp_csr #(.PMP_GRANULARITY(2), .PMP_ENTRIES(16)) dut2 (
    .clk(clk), .rst_l(rst_l), .csr_wr_en(wr_en), .csr_rd_en(rd_en), .csr_addr(addr),
    .csr_wdata(wdata), .csr_rdata(rdata2), .csr_hit(hit2), .pmp_pmpcfg(cfgo2),
    .pmp_pmpaddr(addro2), .mseccfg(msec2), .pmp_update(upd2));

  task automatic do_reset();
    @(negedge clk);
    rst_l = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d0, output logic [31:0] d2);
    addr = a; rd_en = 1'b1;
    #1;
    d0 = rdata0; d2 = rdata2;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a, b, c, x;
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    rd(12'h3A0, a, x); rd(12'h3B0, b, x); rd(12'h747, c, x);
    checks++; if ({a, b, c} !== 96'h0) begin errors++; $display("FAIL reset_reads got %h %h %h exp 0", a, b, c); end
    checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL reset_update got %b exp 0", upd0); end
  endtask

  task automatic test_cfg_write();
    logic [31:0] a, x;
    do_reset();
    wr(12'h3A0, 32'h0000_0F1F);
    checks++; if (upd0 !== 1'b1) begin errors++; $display("FAIL cfg_update got %b exp 1", upd0); end
    rd(12'h3A0, a, x);
    checks++; if (a !== 32'h0000_0F1F) begin errors++; $display("FAIL cfg_read got %h exp 00000f1f", a); end
    @(negedge clk);
    checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL cfg_update_pulse got %b exp 0", upd0); end
    wr(12'h3A1, 32'h0000_0061);
    rd(12'h3A1, a, x);
    checks++; if (a !== 32'h0000_0001) begin errors++; $display("FAIL cfg_reserved got %h exp 00000001", a); end
    checks++; if (cfgo0[4] !== 8'h01) begin errors++; $display("FAIL cfg_out4 got %h exp 01", cfgo0[4]); end
  endtask

  task automatic test_lock();
    logic [31:0] a, x;
    do_reset();
    wr(12'h3A0, 32'h0000_0F9F);
    wr(12'h3B0, 32'h0000_1234);
    checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL lock_addr_update got %b exp 0", upd0); end
    rd(12'h3B0, a, x);
    checks++; if (a !== 32'h0) begin errors++; $display("FAIL lock_addr got %h exp 0", a); end
    wr(12'h3A0, 32'h0);
    checks++; if (upd0 !== 1'b1) begin errors++; $display("FAIL lock_cfg_update got %b exp 1", upd0); end
    rd(12'h3A0, a, x);
    checks++; if (a !== 32'h0000_009F) begin errors++; $display("FAIL lock_cfg got %h exp 0000009f", a); end
  endtask

  task automatic test_tor_lock();
    logic [31:0] a, x;
    do_reset();
    wr(12'h3A0, 32'h0000_8F00);
    wr(12'h3B0, 32'h0000_0055);
    rd(12'h3B0, a, x);
    checks++; if (a !== 32'h0) begin errors++; $display("FAIL tor_lock got %h exp 0", a); end
    do_reset();
    wr(12'h3A0, 32'h0000_9F00);
    wr(12'h3B0, 32'h0000_0055);
    checks++; if (upd0 !== 1'b1) begin errors++; $display("FAIL napot_next_update got %b exp 1", upd0); end
    rd(12'h3B0, a, x);
    checks++; if (a !== 32'h55) begin errors++; $display("FAIL napot_next got %h exp 55", a); end
  endtask

  task automatic test_mml();
    logic [31:0] a, x;
    do_reset();
    wr(12'h3A0, 32'h02);
    checks++; if (upd0 !== 1'b0) begin errors++; $display("FAIL w_only_update got %b exp 0", upd0); end
    rd(12'h3A0, a, x);
    checks++; if (a !== 32'h0) begin errors++; $display("FAIL w_only got %h exp 0", a); end
    wr(12'h747, 32'h1);
    rd(12'h747, a, x);
    checks++; if (a !== 32'h1 || upd0 !== 1'b1) begin errors++; $display("FAIL mml_set got %h/%b exp 1/1", a, upd0); end
    wr(12'h3A0, 32'h02);
    rd(12'h3A0, a, x);
    checks++; if (a !== 32'h02) begin errors++; $display("FAIL mml_w_only got %h exp 02", a); end
    wr(12'h3A0, 32'h8C02);
    rd(12'h3A0, a, x);
    checks++; if (a !== 32'h02 || upd0 !== 1'b0) begin errors++; $display("FAIL mml_lx_block got %h/%b exp 02/0", a, upd0); end
    wr(12'h3A0, 32'h8F02);
    rd(12'h3A0, a, x);
    checks++; if (a !== 32'h8F02) begin errors++; $display("FAIL mml_rwx got %h exp 8f02", a); end
    wr(12'h747, 32'h0);
    rd(12'h747, a, x);
    checks++; if (a !== 32'h1 || upd0 !== 1'b0) begin errors++; $display("FAIL mml_sticky got %h/%b exp 1/0", a, upd0); end
    wr(12'h747, 32'h2);
    checks++; if (msec0 !== 3'b011) begin errors++; $display("FAIL mmwp_out got %b exp 011", msec0); end
  endtask

  task automatic test_rlb();
    logic [31:0] a, x;
    do_reset();
    wr(12'h3A0, 32'h0080_0000);
    wr(12'h747, 32'h4);
    rd(12'h747, a, x);
    checks++; if (a !== 32'h0 || upd0 !== 1'b0) begin errors++; $display("FAIL rlb_blocked got %h/%b exp 0/0", a, upd0); end
    do_reset();
    wr(12'h747, 32'h4);
    rd(12'h747, a, x);
    checks++; if (a !== 32'h4) begin errors++; $display("FAIL rlb_set got %h exp 4", a); end
    wr(12'h3A0, 32'h0080_0000);
    wr(12'h3B2, 32'h0000_ABCD);
    rd(12'h3B2, a, x);
    checks++; if (a !== 32'hABCD) begin errors++; $display("FAIL rlb_addr got %h exp abcd", a); end
    wr(12'h747, 32'h0);
    wr(12'h3B2, 32'h1);
    rd(12'h3B2, a, x);
    checks++; if (a !== 32'hABCD) begin errors++; $display("FAIL rlb_clear_lock got %h exp abcd", a); end
  endtask

  task automatic test_unimpl();
    logic [31:0] a, x;
    do_reset();
    wr(12'h3C4, 32'hFF);
    rd(12'h3C4, a, x);
    checks++; if (a !== 32'h0 || upd0 !== 1'b0 || hit0 !== 1'b1) begin errors++; $display("FAIL unimpl_addr got %h/%b/%b exp 0/0/1", a, upd0, hit0); end
    rd(12'h3A4, a, x);
    checks++; if (a !== 32'h0 || hit0 !== 1'b1) begin errors++; $display("FAIL unimpl_cfg got %h/%b exp 0/1", a, hit0); end
    wr(12'h757, 32'h7);
    rd(12'h757, a, x);
    checks++; if (a !== 32'h0 || upd0 !== 1'b0 || hit0 !== 1'b1) begin errors++; $display("FAIL mseccfgh got %h/%b/%b exp 0/0/1", a, upd0, hit0); end
    addr = 12'h3EF; #1;
    checks++; if (hit0 !== 1'b1) begin errors++; $display("FAIL hit_3ef got %b exp 1", hit0); end
    addr = 12'h3F0; #1;
    checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL hit_3f0 got %b exp 0", hit0); end
    addr = 12'h300; #1;
    checks++; if (hit0 !== 1'b0) begin errors++; $display("FAIL hit_300 got %b exp 0", hit0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, x;
    do_reset();
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 12'h3B3; wdata = 32'h11;
    #1;
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL rd_in_wr got %h exp 0", rdata0); end
    @(negedge clk);
    addr = 12'h3B4; wdata = 32'h22;
    #1;
    checks++; if (upd0 !== 1'b1) begin errors++; $display("FAIL b2b_update1 got %b exp 1", upd0); end
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (upd0 !== 1'b1) begin errors++; $display("FAIL b2b_update2 got %b exp 1", upd0); end
    rd(12'h3B3, a, x);
    checks++; if (a !== 32'h11) begin errors++; $display("FAIL b2b_addr3 got %h exp 11", a); end
    rd(12'h3B4, a, x);
    checks++; if (a !== 32'h22) begin errors++; $display("FAIL b2b_addr4 got %h exp 22", a); end
  endtask

  task automatic test_granularity();
    logic [31:0] a0, a2;
    do_reset();
    wr(12'h3A0, 32'h18);
    wr(12'h3B0, 32'h0);
    rd(12'h3B0, a0, a2);
    checks++; if (a2 !== 32'h1 || a0 !== 32'h0) begin errors++; $display("FAIL g2_napot got %h/%h exp 1/0", a2, a0); end
    checks++; if (addro2[0] !== 32'h0) begin errors++; $display("FAIL g2_stored got %h exp 0", addro2[0]); end
    wr(12'h3A0, 32'h08);
    rd(12'h3B0, a0, a2);
    checks++; if (a2 !== 32'h0) begin errors++; $display("FAIL g2_tor got %h exp 0", a2); end
    wr(12'h3A0, 32'h10);
    checks++; if (upd2 !== 1'b0 || upd0 !== 1'b1) begin errors++; $display("FAIL g2_na4_update got %b/%b exp 0/1", upd2, upd0); end
    rd(12'h3A0, a0, a2);
    checks++; if (a2 !== 32'h08 || a0 !== 32'h10) begin errors++; $display("FAIL g2_na4 got %h/%h exp 08/10", a2, a0); end
    wr(12'h3B0, 32'hFFFF_FFFF);
    rd(12'h3B0, a0, a2);
    checks++; if (a2 !== 32'hFFFF_FFFC || a0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL g2_tor_mask got %h/%h exp fffffffc/ffffffff", a2, a0); end
    checks++; if (addro2[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL g2_stored_full got %h exp ffffffff", addro2[0]); end
    @(negedge clk);
    wr_en = 1'b1; addr = 12'h3A0; wdata = 32'h1F; rst_l = 1'b0;
    @(negedge clk);
    wr_en = 1'b0; rst_l = 1'b1;
    checks++; if (upd0 !== 1'b0 || upd2 !== 1'b0) begin errors++; $display("FAIL rst_mid_update got %b/%b exp 0/0", upd0, upd2); end
    rd(12'h3A0, a0, a2);
    checks++; if (a0 !== 32'h0 || a2 !== 32'h0) begin errors++; $display("FAIL rst_mid_cfg got %h/%h exp 0/0", a0, a2); end
    rd(12'h3B0, a0, a2);
    checks++; if (a0 !== 32'h0 || a2 !== 32'h0) begin errors++; $display("FAIL rst_mid_addr got %h/%h exp 0/0", a0, a2); end
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_lock();
    test_tor_lock();
    test_mml();
    test_rlb();
    test_unimpl();
    test_back_to_back();
    test_granularity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
